// File: rtl/conv_pkg.sv
// Shared types and constant helpers for the convolution row engine.
package conv_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Sized so that the worst case of every tap at full magnitude plus bias cannot overflow
   function automatic int acc_width(input int data_width, input int taps);
      return 2 * data_width + $clog2(taps) + 1;
   endfunction

   function automatic longint sat_max(input int data_width);
      return (longint'(1) <<< (data_width - 1)) - 1;
   endfunction

   function automatic longint sat_min(input int data_width);
      return -(longint'(1) <<< (data_width - 1));
   endfunction

endpackage

// File: rtl/conv_mac_lane.sv
// One output pixel: bias-seeded accumulator with a registered product, then shift and saturate.
// Optional ReLU clamp when CONV_RELU_EN is defined.
module conv_mac_lane
   import conv_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ACC_W      = 21,
   parameter int FRAC_BITS  = 0
)
(
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         load,
   input  logic                         step,
   input  logic                         finish,
   input  logic signed [DATA_WIDTH-1:0] bias,
   input  logic signed [DATA_WIDTH-1:0] pixel,
   input  logic signed [DATA_WIDTH-1:0] weight,
   output logic signed [DATA_WIDTH-1:0] result
);

   localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(sat_max(DATA_WIDTH));
   localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(sat_min(DATA_WIDTH));

   logic signed [2*DATA_WIDTH-1:0] mul;
   logic signed [ACC_W-1:0]        acc;
   logic signed [ACC_W-1:0]        prod;
   logic signed [ACC_W-1:0]        sum;
   logic signed [ACC_W-1:0]        shifted;
   logic signed [DATA_WIDTH-1:0]   sat_val;
   logic signed [DATA_WIDTH-1:0]   out_val;

   // The product is consumed one cycle after it is formed, so the last tap lands on the finish cycle
   always_comb begin
      mul     = pixel * weight;
      sum     = acc + prod;
      shifted = sum >>> FRAC_BITS;
      if (shifted > SAT_HI) begin
         sat_val = SAT_HI[DATA_WIDTH-1:0];
      end else if (shifted < SAT_LO) begin
         sat_val = SAT_LO[DATA_WIDTH-1:0];
      end else begin
         sat_val = shifted[DATA_WIDTH-1:0];
      end
`ifdef CONV_RELU_EN
      out_val = sat_val[DATA_WIDTH-1] ? '0 : sat_val;
`else
      out_val = sat_val;
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc    <= '0;
         prod   <= '0;
         result <= '0;
      end else begin
         if (load) begin
            acc  <= {{(ACC_W-DATA_WIDTH){bias[DATA_WIDTH-1]}}, bias};
            prod <= '0;
         end else if (step) begin
            acc  <= sum;
            prod <= {{(ACC_W-2*DATA_WIDTH){mul[2*DATA_WIDTH-1]}}, mul};
         end
         if (finish) begin
            result <= out_val;
         end
      end
   end

endmodule

// File: rtl/conv_row_engine.sv
// Computes one row of W convolution outputs, one filter tap per cycle across W parallel lanes.
// Define CONV_RELU_EN to clamp negative results to zero.
module conv_row_engine
   import conv_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int D          = 1,
   parameter int W          = 6,
   parameter int F          = 3,
   parameter int FRAC_BITS  = 0
)
(
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            i_valid,
   output logic                            i_ready,
   input  logic [D*F*(W+F-1)*DATA_WIDTH-1:0] i_rows,
   input  logic [D*F*F*DATA_WIDTH-1:0]     i_filter,
   input  logic [DATA_WIDTH-1:0]           i_bias,
   output logic                            o_valid,
   input  logic                            o_ready,
   output logic [W*DATA_WIDTH-1:0]         o_data
);

   localparam int RW    = W + F - 1;
   localparam int DF    = D * F;
   localparam int T     = D * F * F;
   localparam int ACC_W = acc_width(DATA_WIDTH, T);
   localparam int TAP_W = $clog2(T + 1);
   localparam int ROW_W = (DF > 1) ? $clog2(DF) : 1;
   localparam int COL_W = (F > 1) ? $clog2(F) : 1;

   state_t                        state;
   state_t                        next_state;
   logic [DF*RW*DATA_WIDTH-1:0]   rows_q;
   logic [T*DATA_WIDTH-1:0]       filter_q;
   logic [TAP_W-1:0]              tap_q;
   logic [ROW_W-1:0]              row_q;
   logic [COL_W-1:0]              col_q;
   logic                          accept;
   logic                          step;
   logic                          finish;
   logic [RW*DATA_WIDTH-1:0]      cur_row;
   logic signed [DATA_WIDTH-1:0]  cur_wt;
   logic signed [DATA_WIDTH-1:0]  lane_pix [W];

   // MAC runs T tap cycles plus one finish cycle that drains the last registered product
   always_comb begin
      next_state = state;
      i_ready    = (state == IDLE) || ((state == DONE) && o_ready);
      o_valid    = (state == DONE);
      accept     = i_valid && i_ready;
      step       = (state == MAC) && (tap_q < TAP_W'(T));
      finish     = (state == MAC) && (tap_q == TAP_W'(T));
      case (state)
         IDLE:    if (accept) next_state = MAC;
         MAC:     if (finish) next_state = DONE;
         DONE:    if (o_ready) next_state = accept ? MAC : IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         rows_q   <= '0;
         filter_q <= '0;
         tap_q    <= '0;
         row_q    <= '0;
         col_q    <= '0;
      end else begin
         state <= next_state;
         if (accept) begin
            rows_q   <= i_rows;
            filter_q <= i_filter;
            tap_q    <= '0;
            row_q    <= '0;
            col_q    <= '0;
         end else if (step) begin
            tap_q <= tap_q + TAP_W'(1);
            if (col_q == COL_W'(F - 1)) begin
               col_q <= '0;
               row_q <= row_q + ROW_W'(1);
            end else begin
               col_q <= col_q + COL_W'(1);
            end
         end
      end
   end

   // Row index walks channel then row; lane n reads pixel n+col of the selected row
   always_comb begin
      cur_row = '0;
      for (int j = 0; j < DF; j++) begin
         if (row_q == ROW_W'(j)) cur_row = rows_q[(DF-1-j)*RW*DATA_WIDTH +: RW*DATA_WIDTH];
      end
      cur_wt = '0;
      for (int k = 0; k < T; k++) begin
         if (tap_q == TAP_W'(k)) cur_wt = filter_q[(T-1-k)*DATA_WIDTH +: DATA_WIDTH];
      end
      for (int n = 0; n < W; n++) begin
         lane_pix[n] = '0;
         for (int c = 0; c < F; c++) begin
            if (col_q == COL_W'(c)) lane_pix[n] = cur_row[(RW-1-n-c)*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   for (genvar n = 0; n < W; n++) begin : g_lane
      conv_mac_lane #(
         .DATA_WIDTH (DATA_WIDTH),
         .ACC_W      (ACC_W),
         .FRAC_BITS  (FRAC_BITS)
      ) u_lane (
         .clk    (clk),
         .reset  (reset),
         .load   (accept),
         .step   (step),
         .finish (finish),
         .bias   (i_bias),
         .pixel  (lane_pix[n]),
         .weight (cur_wt),
         .result (o_data[(W-1-n)*DATA_WIDTH +: DATA_WIDTH])
      );
   end

endmodule

// File: tb/tb_conv_row_engine.sv
// Bench: a scoreboarded D=2/F=3/W=4/FRAC_BITS=2 engine with random jobs, plus a small D=1 engine for fixed cases.
module tb_conv_row_engine;

   localparam int DW   = 8;
   localparam int D    = 2;
   localparam int F    = 3;
   localparam int W    = 4;
   localparam int FB   = 2;
   localparam int RW   = W + F - 1;
   localparam int T    = D * F * F;
   localparam int NPIX = D * F * RW;
   localparam int AT   = F * F;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic                 i_valid = 1'b0;
   logic                 i_ready;
   logic [NPIX*DW-1:0]   i_rows = '0;
   logic [T*DW-1:0]      i_filter = '0;
   logic [DW-1:0]        i_bias = '0;
   logic                 o_valid;
   logic                 o_ready = 1'b1;
   logic [W*DW-1:0]      o_data;

   logic                 a_i_valid = 1'b0;
   logic                 a_i_ready;
   logic [F*RW*DW-1:0]   a_i_rows = '0;
   logic [AT*DW-1:0]     a_i_filter = '0;
   logic [DW-1:0]        a_i_bias = '0;
   logic                 a_o_valid;
   logic                 a_o_ready = 1'b1;
   logic [W*DW-1:0]      a_o_data;

   conv_row_engine #(.DATA_WIDTH(DW), .D(D), .W(W), .F(F), .FRAC_BITS(FB)) dut (
      .clk(clk), .reset(reset), .i_valid(i_valid), .i_ready(i_ready), .i_rows(i_rows),
      .i_filter(i_filter), .i_bias(i_bias), .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data)
   );

   conv_row_engine #(.DATA_WIDTH(DW), .D(1), .W(W), .F(F), .FRAC_BITS(0)) dut_small (
      .clk(clk), .reset(reset), .i_valid(a_i_valid), .i_ready(a_i_ready), .i_rows(a_i_rows),
      .i_filter(a_i_filter), .i_bias(a_i_bias), .o_valid(a_o_valid), .o_ready(a_o_ready), .o_data(a_o_data)
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int hold_cnt = 0;
   bit rand_bp = 1'b0;
   int last_accept = 0;

   logic [W*DW-1:0] exp_data [$];
   int              exp_edge [$];

   int job_pix [D][F][RW];
   int job_wt  [D][F][F];
   int job_bias;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: actual=%0h required=%0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Plain integer convolution, shift, clamp: the spec's arithmetic without any notion of taps or cycles
   function automatic logic [W*DW-1:0] model_row();
      logic [W*DW-1:0] r;
      longint s;
      r = '0;
      for (int n = 0; n < W; n++) begin
         s = job_bias;
         for (int c = 0; c < D; c++)
            for (int rr = 0; rr < F; rr++)
               for (int k = 0; k < F; k++)
                  s += longint'(job_pix[c][rr][n+k]) * longint'(job_wt[c][rr][k]);
         s = s >>> FB;
         if (s > 127) s = 127;
         if (s < -128) s = -128;
`ifdef CONV_RELU_EN
         if (s < 0) s = 0;
`endif
         r[(W-1-n)*DW +: DW] = DW'(s);
      end
      return r;
   endfunction

   task automatic fill_const(input int pv, input int wv, input int bv);
      for (int c = 0; c < D; c++)
         for (int r = 0; r < F; r++) begin
            for (int p = 0; p < RW; p++) job_pix[c][r][p] = pv;
            for (int k = 0; k < F; k++) job_wt[c][r][k] = wv;
         end
      job_bias = bv;
   endtask

   task automatic fill_random();
      for (int c = 0; c < D; c++)
         for (int r = 0; r < F; r++) begin
            for (int p = 0; p < RW; p++) job_pix[c][r][p] = int'($urandom_range(0, 255)) - 128;
            for (int k = 0; k < F; k++) job_wt[c][r][k] = int'($urandom_range(0, 255)) - 128;
         end
      job_bias = int'($urandom_range(0, 255)) - 128;
   endtask

   task automatic pack_job();
      int e;
      for (int c = 0; c < D; c++)
         for (int r = 0; r < F; r++) begin
            for (int p = 0; p < RW; p++) begin
               e = (c * F + r) * RW + p;
               i_rows[(NPIX-1-e)*DW +: DW] = DW'(job_pix[c][r][p]);
            end
            for (int k = 0; k < F; k++) begin
               e = (c * F + r) * F + k;
               i_filter[(T-1-e)*DW +: DW] = DW'(job_wt[c][r][k]);
            end
         end
      i_bias = DW'(job_bias);
   endtask

   task automatic drive_ready();
      if (hold_cnt > 0) begin
         o_ready = 1'b0;
         if (o_valid) hold_cnt--;
      end else if (rand_bp) begin
         o_ready = ($urandom_range(0, 3) != 0);
      end else begin
         o_ready = 1'b1;
      end
   endtask

   // Presents the current job and records its expected row once the handshake is certain
   task automatic apply_stimulus();
      int waited = 0;
      @(negedge clk);
      pack_job();
      i_valid = 1'b1;
      drive_ready();
      #1;
      while (!i_ready && waited < 200) begin
         @(negedge clk);
         drive_ready();
         #1;
         waited++;
      end
      if (!i_ready) begin
         checks++;
         failures++;
         $display("[TB] FAIL accept_timeout: actual=i_ready low required=accept within 200 cycles");
         i_valid = 1'b0;
      end else begin
         exp_data.push_back(model_row());
         exp_edge.push_back(cyc + 1);
         last_accept = cyc + 1;
      end
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) begin
         @(negedge clk);
         i_valid = 1'b0;
         drive_ready();
      end
   endtask

   task automatic wait_drain();
      int w = 0;
      while (exp_data.size() > 0 && w < 1000) begin
         @(negedge clk);
         i_valid = 1'b0;
         drive_ready();
         w++;
      end
      if (exp_data.size() > 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL drain_timeout: actual=%0d rows pending required=0", exp_data.size());
         exp_data.delete();
         exp_edge.delete();
      end
   endtask

   task automatic run_small(input int pv, input int wv, input int lane_val, input string name);
      int w = 0;
      int edge_a;
      logic [DW-1:0] lv;
      @(negedge clk);
      a_i_rows   = {(F*RW){DW'(pv)}};
      a_i_filter = {(AT){DW'(wv)}};
      a_i_bias   = '0;
      a_i_valid  = 1'b1;
      a_o_ready  = 1'b1;
      #1;
      check_output({name, "_accept"}, 64'(a_i_ready), 64'(1));
      edge_a = cyc + 1;
      @(negedge clk);
      a_i_valid = 1'b0;
      while (!a_o_valid && w < 50) begin
         @(negedge clk);
         w++;
      end
      lv = DW'(lane_val);
      check_output({name, "_latency"}, 64'(cyc), 64'(edge_a + AT + 1));
      check_output({name, "_data"}, 64'(a_o_data), 64'({W{lv}}));
   endtask

   logic [W*DW-1:0] held;
   bit seen = 1'b0;

   // Monitor: pops the scoreboard on each output handshake and polices the handshake rules
   always @(negedge clk) begin
      #2;
      if (reset) begin
         seen = 1'b0;
      end else if (o_valid) begin
         if (!seen) begin
            seen = 1'b1;
            held = o_data;
            if (exp_edge.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL unexpected_row: actual=%0h required=no output", o_data);
            end else begin
               check_output("latency", 64'(cyc), 64'(exp_edge[0] + T + 1));
            end
         end else begin
            check_output("hold_stable", 64'(o_data), 64'(held));
         end
         check_output("i_ready_in_done", 64'(i_ready), 64'(o_ready));
         if (o_ready) begin
            seen = 1'b0;
            if (exp_data.size() > 0) begin
               check_output("row_data", 64'(o_data), 64'(exp_data[0]));
               void'(exp_data.pop_front());
               void'(exp_edge.pop_front());
            end
         end
      end else if (exp_edge.size() > 0 && exp_edge[exp_edge.size()-1] <= cyc) begin
         check_output("i_ready_in_mac", 64'(i_ready), 64'(0));
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: actual=timeout required=finish");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      int first_accept;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      check_output("reset_o_valid", 64'(o_valid), 64'(0));
      check_output("reset_o_data", 64'(o_data), 64'(0));
      check_output("reset_i_ready", 64'(i_ready), 64'(1));

      run_small(1, 1, 9, "small_ones");
      run_small(127, 127, 127, "small_sat_pos");
      run_small(127, -128, -128, "small_sat_neg");
`ifdef CONV_RELU_EN
      run_small(1, -1, 0, "small_neg");
`else
      run_small(1, -1, -9, "small_neg");
`endif

      fill_const(1, 1, 0);      apply_stimulus();
      fill_const(127, 127, 0);  apply_stimulus();
      fill_const(127, -128, 0); apply_stimulus();
      fill_const(1, -1, 0);     apply_stimulus();
      wait_drain();

      $display("[TB] back-pressure hold");
      hold_cnt = 5;
      fill_random();
      apply_stimulus();
      wait_drain();

      $display("[TB] back-to-back pair");
      rand_bp = 1'b0;
      fill_random();
      apply_stimulus();
      first_accept = last_accept;
      fill_random();
      apply_stimulus();
      check_output("back_to_back_accept", 64'(last_accept), 64'(first_accept + T + 2));
      wait_drain();

      $display("[TB] reset during MAC");
      fill_random();
      apply_stimulus();
      repeat (5) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      i_valid = 1'b0;
      exp_data.delete();
      exp_edge.delete();
      @(negedge clk);
      reset = 1'b0;
      #1;
      check_output("abort_o_valid", 64'(o_valid), 64'(0));
      check_output("abort_o_data", 64'(o_data), 64'(0));
      check_output("abort_i_ready", 64'(i_ready), 64'(1));
      fill_const(2, 3, -5);
      apply_stimulus();
      wait_drain();

      $display("[TB] random jobs");
      rand_bp = 1'b1;
      for (int j = 0; j < 30; j++) begin
         fill_random();
         apply_stimulus();
         idle_cycles(int'($urandom_range(0, 2)));
      end
      wait_drain();
      rand_bp = 1'b0;
      idle_cycles(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
